// File: rtl/alu_control_sequencer_pkg.sv
// Shared definitions for the ALU control sequencer.
// Contents: the FSM state encoding, opcode constants, ALU codes and the
// opcode decode helpers (R-format / I-format classification and ALU mapping).
package cpu_ctrl_defs;

  typedef enum logic [3:0] {
    ST_IDLE  = 4'd0,
    ST_T0    = 4'd1,
    ST_T1    = 4'd2,
    ST_T2    = 4'd3,
    ST_T3    = 4'd4,
    ST_T4    = 4'd5,
    ST_T5    = 4'd6,
    ST_PRE_A = 4'd7,
    ST_PRE_B = 4'd8,
    ST_PRE_C = 4'd9
  } state_t;

  localparam logic [4:0] OP_ADD  = 5'b00011;
  localparam logic [4:0] OP_SUB  = 5'b00100;
  localparam logic [4:0] OP_AND  = 5'b00101;
  localparam logic [4:0] OP_OR   = 5'b00110;
  localparam logic [4:0] OP_ADDI = 5'b01100;
  localparam logic [4:0] OP_ANDI = 5'b01101;
  localparam logic [4:0] OP_ORI  = 5'b01110;

  localparam logic [4:0] ALU_ADD = 5'b00011;
  localparam logic [4:0] ALU_SUB = 5'b00100;
  localparam logic [4:0] ALU_AND = 5'b00101;
  localparam logic [4:0] ALU_OR  = 5'b00110;

  function automatic logic is_rfmt(input logic [4:0] op);
    case (op)
      OP_ADD, OP_SUB, OP_AND, OP_OR: return 1'b1;
      default:                       return 1'b0;
    endcase
  endfunction

  function automatic logic is_ifmt(input logic [4:0] op);
    case (op)
      OP_ADDI, OP_ANDI, OP_ORI: return 1'b1;
      default:                  return 1'b0;
    endcase
  endfunction

  // R-format opcodes are their own ALU code; immediates map onto the R code.
  function automatic logic [4:0] alu_code(input logic [4:0] op);
    case (op)
      OP_ADDI: return ALU_ADD;
      OP_ANDI: return ALU_AND;
      OP_ORI:  return ALU_OR;
      default: return op;
    endcase
  endfunction

endpackage

// File: rtl/alu_control_sequencer_mem_wait_counter.sv
// Memory wait down-counter.
// Ports: clk, clr (async active-high), load/load_val (preset), dec
// (decrement, saturating at zero), count (current value), zero (count==0).
module mem_wait_counter #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         clr,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  output logic [W-1:0] count,
  output logic         zero
);

  // Counter register: load has priority over decrement.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      count <= {W{1'b0}};
    end else if (load) begin
      count <= load_val;
    end else if (dec && (count != {W{1'b0}})) begin
      count <= count - {{(W-1){1'b0}}, 1'b1};
    end else begin
      count <= count;
    end
  end

  assign zero = (count == {W{1'b0}});

endmodule

// File: rtl/alu_control_sequencer.sv
// Hardwired control unit for the three-bus CPU datapath.
// Sequences fetch/execute of R- and I-format ALU instructions and a register
// preload (memory word at PC into a selected register).
// Inputs: clk, clr (async active-high), run, pre_req, pre_reg, ir.
// Outputs: datapath strobes, op_sel, one-hot R_rd, busy, done, pre_ack, illegal.
module alu_control_sequencer
  import cpu_ctrl_defs::*;
#(
  parameter int REG_SEL_W = 4,
  parameter int MEM_WAIT  = 0,
  parameter int OPSEL_W   = 5
) (
  input  logic                      clk,
  input  logic                      clr,
  input  logic                      run,
  input  logic                      pre_req,
  input  logic [REG_SEL_W-1:0]      pre_reg,
  input  logic [31:0]               ir,
  output logic                      PC_out,
  output logic                      MAR_in,
  output logic                      IncPC,
  output logic                      Zlo_in,
  output logic                      Zlo_out,
  output logic                      PC_in,
  output logic                      Read,
  output logic                      MDR_in,
  output logic                      MDR_out,
  output logic                      IR_in,
  output logic                      Y_in,
  output logic                      Rin,
  output logic                      R_out,
  output logic                      Gra,
  output logic                      Grb,
  output logic                      Grc,
  output logic                      BAout,
  output logic                      C_out,
  output logic [OPSEL_W-1:0]        op_sel,
  output logic [2**REG_SEL_W-1:0]   R_rd,
  output logic                      busy,
  output logic                      done,
  output logic                      pre_ack,
  output logic                      illegal
);

  localparam logic [3:0] WAIT_INIT = 4'(MEM_WAIT);

  state_t               state;
  logic [REG_SEL_W-1:0] pre_reg_q;
  logic [4:0]           opcode;
  logic                 legal;
  logic [3:0]           wait_count;
  logic                 wait_zero;
  logic                 wait_load;
  logic                 wait_dec;
  logic                 unused_ir;

  assign opcode    = ir[31:27];
  assign legal     = is_rfmt(opcode) || is_ifmt(opcode);
  assign unused_ir = ^ir[26:0];

  // The counter is preset in the state just before each memory-read state.
  assign wait_load = (state == ST_T0) || (state == ST_PRE_A);
  assign wait_dec  = (state == ST_T1) || (state == ST_PRE_B);

  mem_wait_counter #(.W(4)) u_wait (
    .clk      (clk),
    .clr      (clr),
    .load     (wait_load),
    .load_val (WAIT_INIT),
    .dec      (wait_dec),
    .count    (wait_count),
    .zero     (wait_zero)
  );

  // Sequencer state and captured preload target.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state     <= ST_IDLE;
      pre_reg_q <= {REG_SEL_W{1'b0}};
    end else begin
      case (state)
        ST_IDLE: begin
          if (pre_req) begin
            state     <= ST_PRE_A;
            pre_reg_q <= pre_reg;
          end else if (run) begin
            state <= ST_T0;
          end else begin
            state <= ST_IDLE;
          end
        end
        ST_T0:    state <= ST_T1;
        ST_T1:    state <= wait_zero ? ST_T2 : ST_T1;
        ST_T2:    state <= ST_T3;
        ST_T3:    state <= legal ? ST_T4 : ST_IDLE;
        ST_T4:    state <= ST_T5;
        ST_T5:    state <= run ? ST_T0 : ST_IDLE;
        ST_PRE_A: state <= ST_PRE_B;
        ST_PRE_B: state <= wait_zero ? ST_PRE_C : ST_PRE_B;
        ST_PRE_C: state <= ST_IDLE;
        default:  state <= ST_IDLE;
      endcase
    end
  end

  // Moore strobe decode; op_sel also looks at the opcode during T4.
  always_comb begin
    PC_out  = 1'b0; MAR_in = 1'b0; IncPC = 1'b0; Zlo_in  = 1'b0;
    Zlo_out = 1'b0; PC_in  = 1'b0; Read  = 1'b0; MDR_in  = 1'b0;
    MDR_out = 1'b0; IR_in  = 1'b0; Y_in  = 1'b0; Rin     = 1'b0;
    R_out   = 1'b0; Gra    = 1'b0; Grb   = 1'b0; Grc     = 1'b0;
    BAout   = 1'b0; C_out  = 1'b0;
    op_sel  = {OPSEL_W{1'b0}};
    R_rd    = {(2**REG_SEL_W){1'b0}};
    done    = 1'b0; pre_ack = 1'b0; illegal = 1'b0;
    busy    = (state != ST_IDLE);
    case (state)
      ST_T0: begin
        PC_out = 1'b1; MAR_in = 1'b1; IncPC = 1'b1; Zlo_in = 1'b1;
      end
      ST_T1: begin
        Read = 1'b1; MDR_in = 1'b1;
        // Counter still holds its preset value only in the first T1 cycle.
        if (wait_count == WAIT_INIT) begin
          Zlo_out = 1'b1; PC_in = 1'b1;
        end else begin
          Zlo_out = 1'b0; PC_in = 1'b0;
        end
      end
      ST_T2: begin
        MDR_out = 1'b1; IR_in = 1'b1;
      end
      ST_T3: begin
        if (legal) begin
          Grb = 1'b1; BAout = 1'b1; R_out = 1'b1; Y_in = 1'b1;
        end else begin
          illegal = 1'b1;
        end
      end
      ST_T4: begin
        Zlo_in = 1'b1;
        op_sel = OPSEL_W'(alu_code(opcode));
        if (is_ifmt(opcode)) begin
          C_out = 1'b1;
        end else begin
          Grc = 1'b1; R_out = 1'b1;
        end
      end
      ST_T5: begin
        Zlo_out = 1'b1; Gra = 1'b1; Rin = 1'b1; done = 1'b1;
      end
      ST_PRE_A: begin
        PC_out = 1'b1; MAR_in = 1'b1;
      end
      ST_PRE_B: begin
        Read = 1'b1; MDR_in = 1'b1;
      end
      ST_PRE_C: begin
        MDR_out = 1'b1; IncPC = 1'b1; pre_ack = 1'b1;
        R_rd[pre_reg_q] = 1'b1;
      end
      default: begin
        busy = busy;
      end
    endcase
  end

endmodule

// File: tb/tb_alu_control_sequencer.sv
module tb_alu_control_sequencer;

  localparam logic [17:0] M_PC_OUT  = 18'h20000;
  localparam logic [17:0] M_MAR_IN  = 18'h10000;
  localparam logic [17:0] M_INCPC   = 18'h08000;
  localparam logic [17:0] M_ZLO_IN  = 18'h04000;
  localparam logic [17:0] M_ZLO_OUT = 18'h02000;
  localparam logic [17:0] M_PC_IN   = 18'h01000;
  localparam logic [17:0] M_READ    = 18'h00800;
  localparam logic [17:0] M_MDR_IN  = 18'h00400;
  localparam logic [17:0] M_MDR_OUT = 18'h00200;
  localparam logic [17:0] M_IR_IN   = 18'h00100;
  localparam logic [17:0] M_Y_IN    = 18'h00080;
  localparam logic [17:0] M_RIN     = 18'h00040;
  localparam logic [17:0] M_R_OUT   = 18'h00020;
  localparam logic [17:0] M_GRA     = 18'h00010;
  localparam logic [17:0] M_GRB     = 18'h00008;
  localparam logic [17:0] M_GRC     = 18'h00004;
  localparam logic [17:0] M_BAOUT   = 18'h00002;
  localparam logic [17:0] M_C_OUT   = 18'h00001;

  localparam logic [17:0] S_NONE = 18'h00000;
  localparam logic [17:0] S_T0  = M_PC_OUT | M_MAR_IN | M_INCPC | M_ZLO_IN;
  localparam logic [17:0] S_T1F = M_READ | M_MDR_IN | M_ZLO_OUT | M_PC_IN;
  localparam logic [17:0] S_T1N = M_READ | M_MDR_IN;
  localparam logic [17:0] S_T2  = M_MDR_OUT | M_IR_IN;
  localparam logic [17:0] S_T3  = M_GRB | M_BAOUT | M_R_OUT | M_Y_IN;
  localparam logic [17:0] S_T4R = M_GRC | M_R_OUT | M_ZLO_IN;
  localparam logic [17:0] S_T4I = M_C_OUT | M_ZLO_IN;
  localparam logic [17:0] S_T5  = M_ZLO_OUT | M_GRA | M_RIN;
  localparam logic [17:0] S_PA  = M_PC_OUT | M_MAR_IN;
  localparam logic [17:0] S_PB  = M_READ | M_MDR_IN;
  localparam logic [17:0] S_PC  = M_MDR_OUT | M_INCPC;

  localparam logic [31:0] IR_ORI  = 32'h7286_0095;
  localparam logic [31:0] IR_ADD  = 32'h1800_0000;
  localparam logic [31:0] IR_SUB  = 32'h2000_0000;
  localparam logic [31:0] IR_AND  = 32'h2800_0000;
  localparam logic [31:0] IR_ADDI = 32'h6000_0000;
  localparam logic [31:0] IR_ILL  = 32'hF800_0000;

  typedef struct {
    logic        run;
    logic        pre_req;
    logic [3:0]  pre_reg;
    logic [31:0] ir;
    logic [42:0] exp;
  } vec_t;

  logic clk = 1'b0;
  logic clr;
  logic run0, pre_req0, run1, pre_req1;
  logic [3:0] pre_reg0, pre_reg1;
  logic [31:0] ir0, ir1;

  logic [17:0] st0, st1;
  logic [4:0]  op0, op1;
  logic [15:0] rrd0, rrd1;
  logic busy0, done0, ack0, ill0, busy1, done1, ack1, ill1;
  logic [42:0] act0, act1;

  int n_vec = 0;
  int n_err = 0;
  logic [42:0] sb[$];
  vec_t tbl[30];

  always #5 clk = ~clk;

  alu_control_sequencer #(.REG_SEL_W(4), .MEM_WAIT(0), .OPSEL_W(5)) dut0 (
    .clk(clk), .clr(clr), .run(run0), .pre_req(pre_req0), .pre_reg(pre_reg0), .ir(ir0),
    .PC_out(st0[17]), .MAR_in(st0[16]), .IncPC(st0[15]), .Zlo_in(st0[14]),
    .Zlo_out(st0[13]), .PC_in(st0[12]), .Read(st0[11]), .MDR_in(st0[10]),
    .MDR_out(st0[9]), .IR_in(st0[8]), .Y_in(st0[7]), .Rin(st0[6]),
    .R_out(st0[5]), .Gra(st0[4]), .Grb(st0[3]), .Grc(st0[2]),
    .BAout(st0[1]), .C_out(st0[0]),
    .op_sel(op0), .R_rd(rrd0), .busy(busy0), .done(done0), .pre_ack(ack0), .illegal(ill0)
  );

  alu_control_sequencer #(.REG_SEL_W(4), .MEM_WAIT(2), .OPSEL_W(5)) dut1 (
    .clk(clk), .clr(clr), .run(run1), .pre_req(pre_req1), .pre_reg(pre_reg1), .ir(ir1),
    .PC_out(st1[17]), .MAR_in(st1[16]), .IncPC(st1[15]), .Zlo_in(st1[14]),
    .Zlo_out(st1[13]), .PC_in(st1[12]), .Read(st1[11]), .MDR_in(st1[10]),
    .MDR_out(st1[9]), .IR_in(st1[8]), .Y_in(st1[7]), .Rin(st1[6]),
    .R_out(st1[5]), .Gra(st1[4]), .Grb(st1[3]), .Grc(st1[2]),
    .BAout(st1[1]), .C_out(st1[0]),
    .op_sel(op1), .R_rd(rrd1), .busy(busy1), .done(done1), .pre_ack(ack1), .illegal(ill1)
  );

  assign act0 = {st0, op0, rrd0, busy0, done0, ack0, ill0};
  assign act1 = {st1, op1, rrd1, busy1, done1, ack1, ill1};

  function automatic logic [42:0] ex(input logic [17:0] s, input logic [4:0] op,
                                     input logic [15:0] rrd, input logic b,
                                     input logic d, input logic a, input logic il);
    return {s, op, rrd, b, d, a, il};
  endfunction

  function automatic vec_t mk(input logic r, input logic p, input logic [3:0] pr,
                              input logic [31:0] i, input logic [42:0] e);
    vec_t v;
    v.run = r; v.pre_req = p; v.pre_reg = pr; v.ir = i; v.exp = e;
    return v;
  endfunction

  task automatic check(input string tag, input int idx, input logic [42:0] act,
                       input logic [42:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s[%0d]: got strobes=%h op=%b rrd=%h flags=%b, want strobes=%h op=%b rrd=%h flags=%b",
               tag, idx, act[42:25], act[24:20], act[19:4], act[3:0],
               exp[42:25], exp[24:20], exp[19:4], exp[3:0]);
    end
  endtask

  // Drive one vector at the falling edge, queue its expectation, and compare
  // it against the outputs seen after the next rising edge.
  task automatic step(input string tag, input int idx, input int dut, input vec_t v);
    logic [42:0] e;
    if (dut == 0) begin
      run0 = v.run; pre_req0 = v.pre_req; pre_reg0 = v.pre_reg; ir0 = v.ir;
    end else begin
      run1 = v.run; pre_req1 = v.pre_req; pre_reg1 = v.pre_reg; ir1 = v.ir;
    end
    sb.push_back(v.exp);
    @(posedge clk);
    @(negedge clk);
    e = sb.pop_front();
    check(tag, idx, (dut == 0) ? act0 : act1, e);
  endtask

  initial begin
    clr = 1'b1;
    run0 = 1'b0; pre_req0 = 1'b0; pre_reg0 = 4'd0; ir0 = 32'h0;
    run1 = 1'b0; pre_req1 = 1'b0; pre_reg1 = 4'd0; ir1 = 32'h0;

    // MEM_WAIT=0 table: preload, ORI, back-to-back AND, illegal, ADDI.
    tbl[0]  = mk(1'b0, 1'b0, 4'd0, 32'h0,   ex(S_NONE, 5'd0, 16'h0,    1'b0, 1'b0, 1'b0, 1'b0));
    tbl[1]  = mk(1'b0, 1'b1, 4'd5, 32'h0,   ex(S_PA,   5'd0, 16'h0,    1'b1, 1'b0, 1'b0, 1'b0));
    tbl[2]  = mk(1'b0, 1'b0, 4'd0, 32'h0,   ex(S_PB,   5'd0, 16'h0,    1'b1, 1'b0, 1'b0, 1'b0));
    tbl[3]  = mk(1'b0, 1'b0, 4'd0, 32'h0,   ex(S_PC,   5'd0, 16'h0020, 1'b1, 1'b0, 1'b1, 1'b0));
    tbl[4]  = mk(1'b0, 1'b0, 4'd0, 32'h0,   ex(S_NONE, 5'd0, 16'h0,    1'b0, 1'b0, 1'b0, 1'b0));
    tbl[5]  = mk(1'b1, 1'b0, 4'd0, IR_ORI,  ex(S_T0,   5'd0, 16'h0,    1'b1, 1'b0, 1'b0, 1'b0));
    tbl[6]  = mk(1'b1, 1'b0, 4'd0, IR_ORI,  ex(S_T1F,  5'd0, 16'h0,    1'b1, 1'b0, 1'b0, 1'b0));
    tbl[7]  = mk(1'b1, 1'b0, 4'd0, IR_ORI,  ex(S_T2,   5'd0, 16'h0,    1'b1, 1'b0, 1'b0, 1'b0));
    tbl[8]  = mk(1'b1, 1'b0, 4'd0, IR_ORI,  ex(S_T3,   5'd0, 16'h0,    1'b1, 1'b0, 1'b0, 1'b0));
    tbl[9]  = mk(1'b1, 1'b0, 4'd0, IR_ORI,  ex(S_T4I,  5'b00110, 16'h0, 1'b1, 1'b0, 1'b0, 1'b0));
    tbl[10] = mk(1'b0, 1'b0, 4'd0, IR_ORI,  ex(S_T5,   5'd0, 16'h0,    1'b1, 1'b1, 1'b0, 1'b0));
    tbl[11] = mk(1'b0, 1'b0, 4'd0, IR_ORI,  ex(S_NONE, 5'd0, 16'h0,    1'b0, 1'b0, 1'b0, 1'b0));
    tbl[12] = mk(1'b1, 1'b0, 4'd0, IR_AND,  ex(S_T0,   5'd0, 16'h0,    1'b1, 1'b0, 1'b0, 1'b0));
    tbl[13] = mk(1'b1, 1'b0, 4'd0, IR_AND,  ex(S_T1F,  5'd0, 16'h0,    1'b1, 1'b0, 1'b0, 1'b0));
    tbl[14] = mk(1'b1, 1'b0, 4'd0, IR_AND,  ex(S_T2,   5'd0, 16'h0,    1'b1, 1'b0, 1'b0, 1'b0));
    tbl[15] = mk(1'b1, 1'b0, 4'd0, IR_AND,  ex(S_T3,   5'd0, 16'h0,    1'b1, 1'b0, 1'b0, 1'b0));
    tbl[16] = mk(1'b1, 1'b0, 4'd0, IR_AND,  ex(S_T4R,  5'b00101, 16'h0, 1'b1, 1'b0, 1'b0, 1'b0));
    tbl[17] = mk(1'b1, 1'b1, 4'd9, IR_AND,  ex(S_T5,   5'd0, 16'h0,    1'b1, 1'b1, 1'b0, 1'b0));
    // run held and pre_req ignored outside IDLE: T0 follows T5 directly.
    tbl[18] = mk(1'b1, 1'b1, 4'd9, IR_AND,  ex(S_T0,   5'd0, 16'h0,    1'b1, 1'b0, 1'b0, 1'b0));
    tbl[19] = mk(1'b0, 1'b0, 4'd0, IR_ILL,  ex(S_T1F,  5'd0, 16'h0,    1'b1, 1'b0, 1'b0, 1'b0));
    tbl[20] = mk(1'b0, 1'b0, 4'd0, IR_ILL,  ex(S_T2,   5'd0, 16'h0,    1'b1, 1'b0, 1'b0, 1'b0));
    tbl[21] = mk(1'b0, 1'b0, 4'd0, IR_ILL,  ex(S_NONE, 5'd0, 16'h0,    1'b1, 1'b0, 1'b0, 1'b1));
    tbl[22] = mk(1'b0, 1'b0, 4'd0, IR_ILL,  ex(S_NONE, 5'd0, 16'h0,    1'b0, 1'b0, 1'b0, 1'b0));
    tbl[23] = mk(1'b1, 1'b0, 4'd0, IR_ADDI, ex(S_T0,   5'd0, 16'h0,    1'b1, 1'b0, 1'b0, 1'b0));
    tbl[24] = mk(1'b1, 1'b0, 4'd0, IR_ADDI, ex(S_T1F,  5'd0, 16'h0,    1'b1, 1'b0, 1'b0, 1'b0));
    tbl[25] = mk(1'b1, 1'b0, 4'd0, IR_ADDI, ex(S_T2,   5'd0, 16'h0,    1'b1, 1'b0, 1'b0, 1'b0));
    tbl[26] = mk(1'b1, 1'b0, 4'd0, IR_ADDI, ex(S_T3,   5'd0, 16'h0,    1'b1, 1'b0, 1'b0, 1'b0));
    tbl[27] = mk(1'b1, 1'b0, 4'd0, IR_ADDI, ex(S_T4I,  5'b00011, 16'h0, 1'b1, 1'b0, 1'b0, 1'b0));
    tbl[28] = mk(1'b0, 1'b0, 4'd0, IR_ADDI, ex(S_T5,   5'd0, 16'h0,    1'b1, 1'b1, 1'b0, 1'b0));
    tbl[29] = mk(1'b0, 1'b0, 4'd0, IR_ADDI, ex(S_NONE, 5'd0, 16'h0,    1'b0, 1'b0, 1'b0, 1'b0));

    // Reset state while clr is held.
    @(negedge clk);
    #1;
    check("reset0", 0, act0, 43'h0);
    check("reset1", 0, act1, 43'h0);
    @(negedge clk);
    clr = 1'b0;

    for (int i = 0; i < 30; i++) begin
      step("tbl", i, 0, tbl[i]);
    end

    // MEM_WAIT=2, ADD: T1 lasts three cycles, PC_in only in the first.
    step("w2add", 0, 1, mk(1'b1, 1'b0, 4'd0, IR_ADD, ex(S_T0,   5'd0, 16'h0, 1'b1, 1'b0, 1'b0, 1'b0)));
    step("w2add", 1, 1, mk(1'b0, 1'b0, 4'd0, IR_ADD, ex(S_T1F,  5'd0, 16'h0, 1'b1, 1'b0, 1'b0, 1'b0)));
    step("w2add", 2, 1, mk(1'b0, 1'b0, 4'd0, IR_ADD, ex(S_T1N,  5'd0, 16'h0, 1'b1, 1'b0, 1'b0, 1'b0)));
    step("w2add", 3, 1, mk(1'b0, 1'b0, 4'd0, IR_ADD, ex(S_T1N,  5'd0, 16'h0, 1'b1, 1'b0, 1'b0, 1'b0)));
    step("w2add", 4, 1, mk(1'b0, 1'b0, 4'd0, IR_ADD, ex(S_T2,   5'd0, 16'h0, 1'b1, 1'b0, 1'b0, 1'b0)));
    step("w2add", 5, 1, mk(1'b0, 1'b0, 4'd0, IR_ADD, ex(S_T3,   5'd0, 16'h0, 1'b1, 1'b0, 1'b0, 1'b0)));
    step("w2add", 6, 1, mk(1'b0, 1'b0, 4'd0, IR_ADD, ex(S_T4R,  5'b00011, 16'h0, 1'b1, 1'b0, 1'b0, 1'b0)));
    step("w2add", 7, 1, mk(1'b0, 1'b0, 4'd0, IR_ADD, ex(S_T5,   5'd0, 16'h0, 1'b1, 1'b1, 1'b0, 1'b0)));
    step("w2add", 8, 1, mk(1'b0, 1'b0, 4'd0, IR_ADD, ex(S_NONE, 5'd0, 16'h0, 1'b0, 1'b0, 1'b0, 1'b0)));

    // MEM_WAIT=2 preload into R15: PRE_B held three cycles.
    step("w2pre", 0, 1, mk(1'b0, 1'b1, 4'd15, 32'h0, ex(S_PA,   5'd0, 16'h0,    1'b1, 1'b0, 1'b0, 1'b0)));
    step("w2pre", 1, 1, mk(1'b0, 1'b0, 4'd0,  32'h0, ex(S_PB,   5'd0, 16'h0,    1'b1, 1'b0, 1'b0, 1'b0)));
    step("w2pre", 2, 1, mk(1'b0, 1'b0, 4'd0,  32'h0, ex(S_PB,   5'd0, 16'h0,    1'b1, 1'b0, 1'b0, 1'b0)));
    step("w2pre", 3, 1, mk(1'b0, 1'b0, 4'd0,  32'h0, ex(S_PB,   5'd0, 16'h0,    1'b1, 1'b0, 1'b0, 1'b0)));
    step("w2pre", 4, 1, mk(1'b0, 1'b0, 4'd0,  32'h0, ex(S_PC,   5'd0, 16'h8000, 1'b1, 1'b0, 1'b1, 1'b0)));
    step("w2pre", 5, 1, mk(1'b0, 1'b0, 4'd0,  32'h0, ex(S_NONE, 5'd0, 16'h0,    1'b0, 1'b0, 1'b0, 1'b0)));

    // clr asserted mid-cycle during T4 of a SUB: outputs drop at once, no Rin.
    step("clr", 0, 0, mk(1'b1, 1'b0, 4'd0, IR_SUB, ex(S_T0,  5'd0, 16'h0, 1'b1, 1'b0, 1'b0, 1'b0)));
    step("clr", 1, 0, mk(1'b1, 1'b0, 4'd0, IR_SUB, ex(S_T1F, 5'd0, 16'h0, 1'b1, 1'b0, 1'b0, 1'b0)));
    step("clr", 2, 0, mk(1'b1, 1'b0, 4'd0, IR_SUB, ex(S_T2,  5'd0, 16'h0, 1'b1, 1'b0, 1'b0, 1'b0)));
    step("clr", 3, 0, mk(1'b1, 1'b0, 4'd0, IR_SUB, ex(S_T3,  5'd0, 16'h0, 1'b1, 1'b0, 1'b0, 1'b0)));
    step("clr", 4, 0, mk(1'b1, 1'b0, 4'd0, IR_SUB, ex(S_T4R, 5'b00100, 16'h0, 1'b1, 1'b0, 1'b0, 1'b0)));
    #2;
    clr = 1'b1;
    #1;
    check("clr_async", 0, act0, 43'h0);
    @(negedge clk);
    check("clr_hold", 0, act0, 43'h0);
    clr = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step("post_clr", i, 0, mk(1'b0, 1'b0, 4'd0, IR_SUB,
                                ex(S_NONE, 5'd0, 16'h0, 1'b0, 1'b0, 1'b0, 1'b0)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
